// File: rtl/cdc_sector_tx_if.sv
// Byte-path bundle: sector source read port plus CDC byte write port.
interface cdc_sector_tx_if;
    logic        src_rd;
    logic [11:0] src_addr;
    logic        src_ack;
    logic [7:0]  src_dat;
    logic        tx_we;
    logic        tx_we_sync;
    logic        tx_ce;
    logic [11:0] tx_addr;
    logic [7:0]  tx_dato;

    // Transmitter side: issues reads, drives the CDC byte signals.
    modport master (
        output src_rd, src_addr, tx_we, tx_we_sync, tx_ce, tx_addr, tx_dato,
        input  src_ack, src_dat
    );

    // Environment side: source memory answers reads, CDC consumes bytes.
    modport slave (
        input  src_rd, src_addr, tx_we, tx_we_sync, tx_ce, tx_addr, tx_dato,
        output src_ack, src_dat
    );
endinterface

// File: rtl/cdc_sector_tx.sv
// Sector transmitter: streams SECTOR_LEN bytes from the source memory to the
// CDC byte interface, one byte per dclk, with a one-byte prefetch buffer.
module cdc_sector_tx #(
    parameter int unsigned CLK_DIV    = 283,
    parameter int unsigned SECTOR_LEN = 2352
) (
    input  logic            clk_asic,
    input  logic            rst_n,
    input  logic            sec_start,
    input  logic            sec_audio,
    output logic            dclk,
    output logic            busy,
    output logic            done,
    output logic            underrun,
    cdc_sector_tx_if.master bus
);
    localparam logic [11:0] DIV_TOP  = 12'(CLK_DIV - 1);
    localparam logic [11:0] LEN      = 12'(SECTOR_LEN);
    localparam logic [11:0] LAST_IDX = 12'(SECTOR_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, LAST, GAP} state_t;

    state_t      state_q;
    logic [11:0] div_q;
    logic        busy_q, done_q, underrun_q;
    logic        we_q, we_sync_q, ce_q;
    logic [11:0] tx_addr_q;
    logic [7:0]  tx_dato_q;
    logic        pend_q, pend_audio_q;

    logic [7:0]  hold_q, hold_d;
    logic        vld_q, vld_d;
    logic        rd_q, rd_d;
    logic        disc_q, disc_d;
    logic [11:0] src_addr_q, src_addr_d;
    logic [11:0] fptr_q, fptr_d;

    logic        tick, send, ack_ok, avail, start_now, start_audio;
    logic [7:0]  send_dat;

    // Event decode: byte tick, send opportunity, data availability, sector start.
    always_comb begin
        tick        = (div_q == DIV_TOP);
        send        = tick && (state_q == RUN);
        ack_ok      = rd_q && bus.src_ack && !disc_q;
        avail       = vld_q || ack_ok;
        send_dat    = vld_q ? hold_q : (ack_ok ? bus.src_dat : 8'h00);
        start_now   = ((state_q == IDLE) && sec_start) ||
                      ((state_q == GAP) && (pend_q || sec_start));
        start_audio = pend_q ? pend_audio_q : sec_audio;
    end

    // Prefetch engine. fptr always names the next address not yet requested;
    // on a missed byte the stale read is flagged for discard, or if none was
    // outstanding the pointer skips the missed address, so addresses never slip.
    always_comb begin
        vld_d      = vld_q;
        hold_d     = hold_q;
        rd_d       = rd_q;
        disc_d     = disc_q;
        src_addr_d = src_addr_q;
        fptr_d     = fptr_q;
        if (rd_q && bus.src_ack) begin
            rd_d   = 1'b0;
            disc_d = 1'b0;
            if (!disc_q && (state_q == RUN)) begin
                vld_d  = 1'b1;
                hold_d = bus.src_dat;
            end
        end
        if (start_now) begin
            vld_d  = 1'b0;
            fptr_d = '0;
            disc_d = rd_q && !bus.src_ack;
        end else if (send) begin
            vld_d = 1'b0;
            if (!avail) begin
                if (rd_q && !bus.src_ack && !disc_q) begin
                    disc_d = 1'b1;
                end else if (fptr_q < LEN) begin
                    fptr_d = fptr_q + 12'd1;
                end
            end
        end
        if ((start_now || (state_q == RUN)) && !rd_d && !vld_d && (fptr_d < LEN)) begin
            rd_d       = 1'b1;
            src_addr_d = fptr_d;
            fptr_d     = fptr_d + 12'd1;
        end
    end

    // Free-running byte-clock divider.
    always_ff @(posedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (div_q == DIV_TOP) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 12'd1;
        end
    end

    // Prefetch register state.
    always_ff @(posedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            vld_q      <= 1'b0;
            rd_q       <= 1'b0;
            disc_q     <= 1'b0;
            src_addr_q <= '0;
            fptr_q     <= '0;
        end else begin
            hold_q     <= hold_d;
            vld_q      <= vld_d;
            rd_q       <= rd_d;
            disc_q     <= disc_d;
            src_addr_q <= src_addr_d;
            fptr_q     <= fptr_d;
        end
    end

    // Sector FSM with registered CDC-side outputs and one-deep request pending.
    always_ff @(posedge clk_asic or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
            we_q         <= 1'b0;
            we_sync_q    <= 1'b0;
            ce_q         <= 1'b0;
            tx_addr_q    <= '0;
            tx_dato_q    <= '0;
            pend_q       <= 1'b0;
            pend_audio_q <= 1'b0;
        end else begin
            we_sync_q <= 1'b0;
            done_q    <= 1'b0;
            if (sec_start && ((state_q == RUN) || (state_q == LAST)) && !pend_q) begin
                pend_q       <= 1'b1;
                pend_audio_q <= sec_audio;
            end
            if (start_now) begin
                state_q    <= RUN;
                we_q       <= 1'b1;
                busy_q     <= 1'b1;
                ce_q       <= !start_audio;
                underrun_q <= 1'b0;
                tx_addr_q  <= '0;
                pend_q     <= 1'b0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (send) begin
                            we_sync_q <= 1'b1;
                            tx_dato_q <= send_dat;
                            if (!avail) begin
                                underrun_q <= 1'b1;
                            end
                        end
                        if (we_sync_q) begin
                            if (tx_addr_q == LAST_IDX) begin
                                state_q <= LAST;
                            end else begin
                                tx_addr_q <= tx_addr_q + 12'd1;
                            end
                        end
                    end
                    LAST: begin
                        we_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= GAP;
                    end
                    GAP:     state_q <= IDLE;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign dclk           = tick;
    assign busy           = busy_q;
    assign done           = done_q;
    assign underrun       = underrun_q;
    assign bus.src_rd     = rd_q;
    assign bus.src_addr   = src_addr_q;
    assign bus.tx_we      = we_q;
    assign bus.tx_we_sync = we_sync_q;
    assign bus.tx_ce      = ce_q;
    assign bus.tx_addr    = tx_addr_q;
    assign bus.tx_dato    = tx_dato_q;
endmodule
